cla_16_bit_seq: RTL and testbench
=================================

CLA_16_BIT_SEQ -- requirements
Module: cla_16_bit_seq

Interface
REQ-001 SHALL have no parameters; operand width fixed at 16 bits, processed as four 4-bit slices.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  input  1  request; sampled on a clk edge.
REQ-006 SHALL have port: a  input  16  operand A; sampled with start.
REQ-007 SHALL have port: b  input  16  operand B; sampled with start.
REQ-008 SHALL have port: cin  input  1  carry-in; sampled with start.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: s  output  16  sum.
REQ-012 SHALL have port: cout  output  1  carry-out.
REQ-013 SHALL have port: BP  output  1  16-bit block propagate, AND of all a[i]^b[i].
REQ-014 SHALL have port: BG  output  1  16-bit block generate, independent of cin.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL latch a, b, cin, clear slice counter to 0, clear accumulated P/G, and enter RUN.
REQ-017 In RUN, each edge SHALL compute slice k (bits 4k+3:4k) with the running carry, write s[4k+3:4k], update carry, then increment k.
REQ-018 Group accumulation per slice SHALL be: P_acc = P_acc & BP_k; G_acc = BG_k | (BP_k & G_acc); initial P_acc=1, G_acc=0.
REQ-019 After slice 3 is written, SHALL enter DONE; cout, BP, BG SHALL be updated on that same edge.
REQ-020 Latency: start accepted at edge 0; slices at edges 1-4; done=1 for exactly the cycle after edge 4.
REQ-021 busy SHALL be 1 from edge 0 through edge 4; 0 in IDLE and DONE.
REQ-022 DONE SHALL return to IDLE after one cycle unless start=1, which starts back-to-back (done and new busy in the same cycle).
REQ-023 start while in RUN SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-024 s, cout, BP, BG SHALL hold last result until the next accepted start; s SHALL update one slice at a time during RUN.
REQ-025 cout SHALL equal BG | (BP & cin) and match carry out of the 16-bit sum, modulo 2^16 wrap.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, counter 0, busy=0, done=0, s=0, cout=0, BP=0, BG=0.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit) and constants SLICE_W=4, N_SLICES=4.
REQ-029 One combinational sub-module, cla_slice_4, SHALL compute 4-bit sum, slice carry out, BP_k, BG_k; it is instantiated once and time-multiplexed.

Verification
REQ-030 a=0x0000, b=0x0000, cin=0 -> s=0x0000, cout=0, BP=0, BG=0, done 5 cycles after start.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, BP=0, BG=1.
REQ-032 a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1, BP=1, BG=0.
REQ-033 a=0x1234, b=0x4321, cin=0, second start pulsed at edge 2 with a=0xFFFF -> ignored; s=0x5555, cout=0.
REQ-034 rst_n low at edge 2 of an operation -> all outputs 0, no done; then a=0x000B, b=0x000C, cin=0 -> s=0x0017, cout=0.
REQ-035 start held high across DONE with a=0x8000, b=0x8000 -> back-to-back run, s=0x0000, cout=1, BG=1, BP=0.

Source files
------------

// File: rtl/cla_16_bit_seq_pkg.sv
// Shared definitions for the sequential 16-bit carry-lookahead adder:
// FSM state encoding and slice geometry.
package cla_16_bit_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int SLICE_W  = 4;
  localparam int N_SLICES = 4;

  // Index of the final slice; reaching it ends the RUN phase.
  localparam logic [1:0] LAST_SLICE = 2'(N_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla_16_bit_seq_if.sv
// Bundle of the adder's request/result signals.
// Handshake: the master raises start together with a/b/cin; the request is
// taken on a rising clk edge only while the adder is not busy. Results
// (s, cout, BP, BG) are valid in the single cycle where done=1 and are held
// afterwards until the next accepted start.
interface cla_16_bit_seq_if;
  import cla_16_bit_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cin;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] s;
  logic              cout;
  logic              BP;
  logic              BG;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, BP, BG
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, BP, BG
  );

endinterface

// File: rtl/cla_16_bit_seq_slice.sv
// Combinational 4-bit carry-lookahead slice: sum, carry out and the slice's
// block propagate/generate terms.
module cla_slice_4
  import cla_16_bit_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               bp,
  output logic               bg
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  // Lookahead carries expanded from bit propagate/generate terms.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    bp   = &p;
    bg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    c[4] = bg | (bp & cin);
    sum  = p ^ c[SLICE_W-1:0];
    cout = c[4];
  end

endmodule

// File: rtl/cla_16_bit_seq.sv
// Sequential 16-bit adder: one 4-bit lookahead slice reused over four
// cycles, least significant slice first, with running carry and running
// group propagate/generate.
module cla_16_bit_seq
  import cla_16_bit_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic              BP,
  output logic              BG
);

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                carry_q, carry_d;
  logic                p_acc_q, p_acc_d;
  logic                g_acc_q, g_acc_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic                cout_q, cout_d;
  logic                bp_q, bp_d;
  logic                bg_q, bg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [3:0]          slice_lsb;
  logic [SLICE_W-1:0]  sl_a, sl_b, sl_sum;
  logic                sl_cout, sl_bp, sl_bg;

  // Select the operand nibbles of the slice currently being processed.
  always_comb begin
    slice_lsb = {k_q, 2'b00};
    sl_a      = a_q[slice_lsb +: SLICE_W];
    sl_b      = b_q[slice_lsb +: SLICE_W];
  end

  cla_slice_4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .bp   (sl_bp),
    .bg   (sl_bg)
  );

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    bp_d    = bp_q;
    bg_d    = bg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = 2'd0;
          p_acc_d = 1'b1;
          g_acc_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A start seen here is deliberately ignored; operands stay latched.
        s_d[slice_lsb +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        p_acc_d = p_acc_q & sl_bp;
        g_acc_d = sl_bg | (sl_bp & g_acc_q);
        k_d     = k_q + 2'd1;
        if (k_q == LAST_SLICE) begin
          cout_d  = sl_cout;
          bp_d    = p_acc_d;
          bg_d    = g_acc_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      p_acc_q <= 1'b1;
      g_acc_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      bp_q    <= 1'b0;
      bg_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      p_acc_q <= p_acc_d;
      g_acc_q <= g_acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      bp_q    <= bp_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign BP   = bp_q;
  assign BG   = bg_q;

endmodule

// File: tb/tb_cla_16_bit_seq.sv
// Bench for the sequential 16-bit lookahead adder: vector table, corner
// sequences (ignored start, reset abort, back-to-back), randomized operands
// against an arithmetic reference.
module tb_cla_16_bit_seq;

  logic clk;
  logic rst_n;

  cla_16_bit_seq_if bus ();

  cla_16_bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.start),
    .a     (bus.a),
    .b     (bus.b),
    .cin   (bus.cin),
    .busy  (bus.busy),
    .done  (bus.done),
    .s     (bus.s),
    .cout  (bus.cout),
    .BP    (bus.BP),
    .BG    (bus.BG)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_s;
    logic        exp_cout;
    logic        exp_bp;
    logic        exp_bg;
  } vec_t;

  int n_pass;
  int n_total;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain 17-bit addition; block generate is the carry out with
  // no carry in, block propagate is every bit pair differing.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] s, output logic co,
                       output logic bp, output logic bg);
    logic [16:0] full;
    logic [16:0] nocin;
    full  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    nocin = {1'b0, a} + {1'b0, b};
    s     = full[15:0];
    co    = full[16];
    bg    = nocin[16];
    bp    = ((a ^ b) == 16'hFFFF);
  endtask

  // Driver: called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done, counting negedges since the accepting edge (bounded).
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic ebp, input logic ebg);
    check({tag, "_s"},    32'(bus.s),    32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "_bp"},   32'(bus.BP),   32'(ebp));
    check({tag, "_bg"},   32'(bus.BG),   32'(ebg));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check_result(tag, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int cyc;
    int n_done;
    logic [15:0] ms;
    logic mc, mbp, mbg;

    n_pass = 0;
    n_total = 0;
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
      wait_done(1, cyc);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd5);
      check($sformatf("vec%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
      check_result($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout,
                   vecs[i].exp_bp, vecs[i].exp_bg);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Start during RUN is ignored; s fills slice by slice
    start_op(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    check("ign_slice0", 32'(bus.s[3:0]), 32'h5);
    check("ign_slice1_pending", 32'(bus.s[7:4]), 32'h0);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, cyc);
    check("ign_latency", 32'(cyc), 32'd5);
    check("ign_s", 32'(bus.s), 32'h5555);
    check("ign_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation
    start_op(16'hAAAA, 16'h5555, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    start_op(16'h000B, 16'h000C, 1'b0);
    wait_done(1, cyc);
    check("postrst_latency", 32'(cyc), 32'd5);
    check("postrst_s", 32'(bus.s), 32'h0017);
    check("postrst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);

    // Back-to-back with start held high across DONE
    bus.start = 1'b1;
    bus.a     = 16'h8000;
    bus.b     = 16'h8000;
    bus.cin   = 1'b0;
    @(negedge clk);
    wait_done(1, cyc);
    check("b2b_lat1", 32'(cyc), 32'd5);
    check_result("b2b_1", 16'h0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_again", 32'(bus.busy), 32'd1);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done(1, cyc);
    check("b2b_lat2", 32'(cyc), 32'd5);
    check_result("b2b_2", 16'h0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // Randomized operands against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic rc;
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = (i % 5 == 0) ? ~ra : 16'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, ms, mc, mbp, mbg);
      exp_q.push_back(ms);
      start_op(ra, rb, rc);
      wait_done(1, cyc);
      check($sformatf("rnd%0d_latency", i), 32'(cyc), 32'd5);
      check($sformatf("rnd%0d_s", i), 32'(bus.s), 32'(exp_q.pop_front()));
      check($sformatf("rnd%0d_cout", i), 32'(bus.cout), 32'(mc));
      check($sformatf("rnd%0d_bp", i), 32'(bus.BP), 32'(mbp));
      check($sformatf("rnd%0d_bg", i), 32'(bus.BG), 32'(mbg));
      repeat (1 + (i % 2)) @(negedge clk);
    end

    // Results hold while idle
    repeat (3) @(negedge clk);
    check("hold_s", 32'(bus.s), 32'(ms));
    check("hold_cout", 32'(bus.cout), 32'(mc));
    check("hold_done", 32'(bus.done), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
